// File: rtl/fec_pkg.sv
// Shared types and helpers for the FEC receive deframer.
// Frame layout is data matrix, then row parity, then column parity.
package fec_pkg;

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_PAYLOAD = 2'd1
  } deframer_st_t;

  localparam logic [7:0] DEF_SYNC_WORD = 8'hA5;

  function automatic int fec_frame_len(input int width, input int depth);
    return width * depth + depth + width;
  endfunction

endpackage

// File: rtl/fec_sync_det.sv
// Sync hunter: shift register, saturating fill count, comparator.
// match is combinational on the current valid bit; no backpressure.
module fec_sync_det
  import fec_pkg::*;
#(
  parameter int                   SYNC_LEN  = 8,
  parameter logic [SYNC_LEN-1:0]  SYNC_WORD = SYNC_LEN'(DEF_SYNC_WORD)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic bit_vld,
  input  logic bit_dat,
  input  logic clear,
  output logic match
);

  localparam int FILL_W = $clog2(SYNC_LEN + 1);

  logic [SYNC_LEN-1:0] shift_q, shift_d;
  logic [FILL_W-1:0]   fill_q, fill_d;

  always_comb begin
    shift_d = shift_q;
    fill_d  = fill_q;
    if (en && bit_vld) begin
      shift_d = {shift_q[SYNC_LEN-2:0], bit_dat};
      if (fill_q != FILL_W'(SYNC_LEN)) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
    match = en && bit_vld && (shift_d == SYNC_WORD) && (fill_d >= FILL_W'(SYNC_LEN));
    // A fresh hunt must see SYNC_LEN new bits; payload bits never count.
    if (clear) begin
      shift_d = '0;
      fill_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q <= '0;
      fill_q  <= '0;
    end else begin
      shift_q <= shift_d;
      fill_q  <= fill_d;
    end
  end

endmodule

// File: rtl/fec_deframer.sv
// Serial sync hunt + FEC frame assembly into one holding register.
// frame_valid 1 cycle after last bit; a frame completing while held and not accepted is dropped (overrun).
module fec_deframer
  import fec_pkg::*;
#(
  parameter int                  WIDTH     = 4,
  parameter int                  DEPTH     = 4,
  parameter int                  SYNC_LEN  = 8,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = SYNC_LEN'(DEF_SYNC_WORD)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx_bit,
  input  logic                         rx_valid,
  output logic [WIDTH-1:0][DEPTH-1:0]  data_out,
  output logic [DEPTH-1:0]             row_parity,
  output logic [WIDTH-1:0]             col_parity,
  output logic                         frame_valid,
  input  logic                         frame_ready,
  output logic                         sync_lock,
  output logic                         overrun
);

  localparam int N     = fec_frame_len(WIDTH, DEPTH);
  localparam int MAT   = WIDTH * DEPTH;
  localparam int CNT_W = $clog2(N);

  deframer_st_t               state_q, state_d;
  logic [CNT_W-1:0]           bit_cnt_q, bit_cnt_d;
  logic [N-1:0]               asm_q, asm_d;
  logic [WIDTH-1:0][DEPTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]           row_q, row_d;
  logic [WIDTH-1:0]           col_q, col_d;
  logic                       fv_q, fv_d;
  logic                       ovr_q, ovr_d;
  logic                       lock_q, lock_d;

  logic [N-1:0] frame_bits;
  logic         hunt;
  logic         match;
  logic         complete;

  assign hunt = (state_q == S_HUNT);

  fec_sync_det #(
    .SYNC_LEN  (SYNC_LEN),
    .SYNC_WORD (SYNC_WORD)
  ) u_sync_det (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (hunt),
    .bit_vld (rx_valid),
    .bit_dat (rx_bit),
    .clear   (complete),
    .match   (match)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    asm_d     = asm_q;
    data_d    = data_q;
    row_d     = row_q;
    col_d     = col_q;
    ovr_d     = 1'b0;
    complete  = 1'b0;
    fv_d      = fv_q && !frame_ready;

    // Payload index k maps straight onto the flat frame: data[k/DEPTH][k%DEPTH] is bit k.
    frame_bits            = asm_q;
    frame_bits[bit_cnt_q] = rx_bit;

    case (state_q)
      S_HUNT: begin
        if (match) begin
          state_d   = S_PAYLOAD;
          bit_cnt_d = '0;
        end
      end
      S_PAYLOAD: begin
        if (rx_valid) begin
          asm_d = frame_bits;
          if (bit_cnt_q == CNT_W'(N - 1)) begin
            complete  = 1'b1;
            state_d   = S_HUNT;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_HUNT;
    endcase

    if (complete) begin
      if (!fv_q || frame_ready) begin
        data_d = frame_bits[MAT-1:0];
        row_d  = frame_bits[MAT +: DEPTH];
        col_d  = frame_bits[MAT+DEPTH +: WIDTH];
        fv_d   = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    lock_d = (state_d == S_PAYLOAD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_HUNT;
      bit_cnt_q <= '0;
      asm_q     <= '0;
      data_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      fv_q      <= 1'b0;
      ovr_q     <= 1'b0;
      lock_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      asm_q     <= asm_d;
      data_q    <= data_d;
      row_q     <= row_d;
      col_q     <= col_d;
      fv_q      <= fv_d;
      ovr_q     <= ovr_d;
      lock_q    <= lock_d;
    end
  end

  assign data_out    = data_q;
  assign row_parity  = row_q;
  assign col_parity  = col_q;
  assign frame_valid = fv_q;
  assign overrun     = ovr_q;
  assign sync_lock   = lock_q;

endmodule

// File: tb/tb_fec_deframer.sv
// Directed + randomized bench for fec_deframer with a queue-based reference model.
module tb_fec_deframer;

  localparam int W = 4;
  localparam int D = 4;
  localparam int N = W * D + D + W;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 rx_bit;
  logic                 rx_valid;
  logic [W-1:0][D-1:0]  data_out;
  logic [D-1:0]         row_parity;
  logic [W-1:0]         col_parity;
  logic                 frame_valid;
  logic                 frame_ready;
  logic                 sync_lock;
  logic                 overrun;

  always #5 clk = ~clk;

  fec_deframer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_bit      (rx_bit),
    .rx_valid    (rx_valid),
    .data_out    (data_out),
    .row_parity  (row_parity),
    .col_parity  (col_parity),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .sync_lock   (sync_lock),
    .overrun     (overrun)
  );

  int n_chk = 0;
  int n_fail = 0;
  int lock_cycles = 0;

  // Reference model state
  bit                  m_lock;
  bit                  m_fv;
  bit                  m_ovr;
  logic [W-1:0][D-1:0] m_data;
  logic [D-1:0]        m_row;
  logic [W-1:0]        m_col;
  bit                  m_hist[$];
  bit                  m_pay[$];

  bit q_bits[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit vld, input bit b, input bit rdy);
    bit         nfv;
    bit         novr;
    bit         dummy;
    logic [7:0] win;
    if (!rst) begin
      m_lock = 0; m_fv = 0; m_ovr = 0;
      m_data = '0; m_row = '0; m_col = '0;
      m_hist.delete(); m_pay.delete();
      return;
    end
    nfv  = m_fv && !rdy;
    novr = 0;
    if (vld) begin
      if (!m_lock) begin
        m_hist.push_back(b);
        if (m_hist.size() > 8) dummy = m_hist.pop_front();
        if (m_hist.size() == 8) begin
          win = '0;
          foreach (m_hist[i]) win = {win[6:0], m_hist[i]};
          if (win == 8'hA5) begin
            m_lock = 1;
            m_pay.delete();
          end
        end
      end else begin
        m_pay.push_back(b);
        if (m_pay.size() == N) begin
          m_lock = 0;
          m_hist.delete();
          if (!m_fv || rdy) begin
            for (int k = 0; k < N; k++) begin
              if (k < W * D)          m_data[k / D][k % D] = m_pay[k];
              else if (k < W * D + D) m_row[k - W * D]     = m_pay[k];
              else                    m_col[k - W * D - D] = m_pay[k];
            end
            nfv = 1;
          end else begin
            novr = 1;
          end
          m_pay.delete();
        end
      end
    end
    m_fv  = nfv;
    m_ovr = novr;
  endtask

  task automatic tick(input bit rst, input bit vld, input bit b, input bit rdy);
    model_edge(rst, vld, b, rdy);
    rst_n = rst; rx_valid = vld; rx_bit = b; frame_ready = rdy;
    @(posedge clk);
    #1;
    if (sync_lock === 1'b1) lock_cycles++;
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    chk("overrun",     32'(overrun),     32'(m_ovr));
    chk("sync_lock",   32'(sync_lock),   32'(m_lock));
    chk("data_out",    32'(data_out),    32'(m_data));
    chk("row_parity",  32'(row_parity),  32'(m_row));
    chk("col_parity",  32'(col_parity),  32'(m_col));
  endtask

  function automatic bit pick_rdy(input int mode);
    if (mode == 2) return 1'($urandom);
    return (mode != 0);
  endfunction

  task automatic send_q(input int gap_min, input int gap_max, input int rdy_mode);
    bit b;
    int gap;
    while (q_bits.size() > 0) begin
      gap = int'($urandom_range(gap_max, gap_min));
      for (int g = 0; g < gap; g++) tick(1, 0, 1'($urandom), pick_rdy(rdy_mode));
      b = q_bits.pop_front();
      tick(1, 1, b, pick_rdy(rdy_mode));
    end
  endtask

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) q_bits.push_back(v[i]);
  endtask

  task automatic push_sync();
    push_bits(32'hA5, 8);
  endtask

  task automatic push_payload(input logic [N-1:0] p, input int n);
    for (int k = 0; k < n; k++) q_bits.push_back(p[k]);
  endtask

  // Clean-frame payload: data bits 1,0,0,0 repeated; row parity 1111; col parity 0000.
  localparam logic [N-1:0] CLEAN = 24'h0F1111;

  task automatic chk_clean(input string tag);
    chk({tag, "_fv"},   32'(frame_valid), 32'd1);
    chk({tag, "_data"}, 32'(data_out),    32'h1111);
    chk({tag, "_row"},  32'(row_parity),  32'hF);
    chk({tag, "_col"},  32'(col_parity),  32'h0);
  endtask

  initial begin
    bit last;
    rst_n = 0; rx_valid = 0; rx_bit = 0; frame_ready = 0;
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("reset_fv",   32'(frame_valid), 32'd0);
    chk("reset_lock", 32'(sync_lock),   32'd0);
    chk("reset_data", 32'(data_out),    32'd0);

    // Clean frame
    lock_cycles = 0;
    push_sync(); push_payload(CLEAN, N);
    send_q(0, 0, 1);
    chk_clean("clean");
    chk("clean_lock_cycles", 32'(lock_cycles), 32'd24);
    tick(1, 0, 0, 1);
    chk("clean_fv_drop", 32'(frame_valid), 32'd0);

    // Bit slip and false sync
    lock_cycles = 0;
    push_bits(32'b101, 3);
    push_bits(32'b10100100, 8);
    push_sync(); push_payload(CLEAN, N);
    send_q(0, 0, 1);
    chk_clean("slip");
    chk("slip_lock_cycles", 32'(lock_cycles), 32'd24);
    tick(1, 0, 0, 1);

    // Backpressure: A held, B dropped with overrun
    push_sync(); push_payload('0, N);
    send_q(0, 0, 0);
    push_sync(); push_payload(CLEAN, N);
    send_q(0, 0, 0);
    chk("bp_overrun", 32'(overrun),     32'd1);
    chk("bp_fv",      32'(frame_valid), 32'd1);
    chk("bp_data_a",  32'(data_out),    32'h0);
    tick(1, 0, 0, 0);
    chk("bp_overrun_pulse", 32'(overrun), 32'd0);
    tick(1, 0, 0, 1);
    chk("bp_release", 32'(frame_valid), 32'd0);

    // Simultaneous accept and complete
    push_sync(); push_payload('0, N);
    send_q(0, 0, 0);
    push_sync(); push_payload(CLEAN, N);
    last = q_bits.pop_back();
    send_q(0, 0, 0);
    tick(1, 1, last, 1);
    chk_clean("simul");
    chk("simul_overrun", 32'(overrun), 32'd0);
    tick(1, 0, 0, 1);

    // Gapped input
    push_sync(); push_payload(CLEAN, N);
    send_q(3, 3, 1);
    chk_clean("gapped");
    tick(1, 0, 0, 1);

    // Reset mid-frame
    push_sync(); push_payload('1, 10);
    send_q(0, 0, 1);
    tick(0, 0, 0, 1);
    chk("rst_mid_lock", 32'(sync_lock),   32'd0);
    chk("rst_mid_fv",   32'(frame_valid), 32'd0);
    chk("rst_mid_data", 32'(data_out),    32'd0);
    push_sync(); push_payload(CLEAN, N);
    send_q(0, 0, 1);
    chk_clean("post_rst");
    tick(1, 0, 0, 1);

    // Randomized frames: noise, gaps, random backpressure
    for (int f = 0; f < 25; f++) begin
      push_bits(32'($urandom), int'($urandom_range(6, 0)));
      push_sync();
      push_payload(N'($urandom), N);
      send_q(0, 2, 2);
    end
    for (int i = 0; i < 4; i++) tick(1, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
